voter_id_registry: RTL and testbench
====================================

# voter_id_registry

Parametrised registry of voter IDs that have already cast a vote, replacing the fixed 16-entry, level-sensitive voter-ID database. It sits between the ballot controller and the vote counter. On each request it runs a sequential search; optionally it records a new ID. It reports duplicate, recorded and overflow status through a req/ready/done handshake. Per-entry occupancy comes from a contiguous fill count, so ID value 0 is a legal voter ID and all 2**ADDRESS_SIZE entries are usable.

## Interface
- WORD_SIZE, 5, voter ID width in bits
- ADDRESS_SIZE, 4, log2 of registry depth; DEPTH = 2**ADDRESS_SIZE entries
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- mode  input  1  voting mode enable; must be 1 for a request to be accepted
- control  input  1  ballot-unit enable; must be 1 for a request to be accepted
- req  input  1  request strobe; sampled only while ready=1
- op  input  1  0 = query only; 1 = query-and-record
- voter_id  input  WORD_SIZE  ID to check, sampled with req
- clear  input  1  empties the registry; honoured only while ready=1
- ready  output  1  high in IDLE; a request may be accepted
- done  output  1  one-cycle pulse; the result flags are valid
- found  output  1  the ID was already present (duplicate vote)
- recorded  output  1  the ID was absent and has now been written
- overflow  output  1  record requested on a miss while the registry was full
- count  output  ADDRESS_SIZE+1  number of occupied entries, 0..DEPTH
- full  output  1  count == DEPTH

## Operation
- Storage: a DEPTH x WORD_SIZE array. Entries 0..count-1 are valid. Contents at or above count are don't-care and are never compared.
- Accept: occurs on an edge where state=IDLE, req=1, mode=1 and control=1. At accept the block latches voter_id and op, sets idx to 0 and clears found, recorded and overflow.
- States:
  - IDLE: ready=1.
    - On accept with count≠0, go to SCAN.
    - On accept with count=0, go to WRITE if op=1, otherwise go to RESP.
  - SCAN: compare mem[idx] with the latched ID, one entry per cycle.
    - Hit: set found=1 and go to RESP.
    - Miss with idx=count-1: go to WRITE if op=1 and full=0. If op=1 and full=1, set overflow=1 and go to RESP. If op=0, go to RESP.
    - Otherwise: increment idx.
  - WRITE: mem[count] <= ID, count increments, recorded=1, then go to RESP.
  - RESP: done=1 for this single cycle, then go to IDLE.
- clear: takes effect only while ready=1. It sets count=0 and leaves the flags unchanged. If clear and req arrive on the same edge, clear wins and req is ignored, with no done. clear asserted while busy is ignored.
- mode and control gate only the accept. Dropping either one mid-operation does not abort the operation, which runs to RESP.
- found, recorded and overflow are registered, mutually exclusive, and held from RESP until the next accept.
- req asserted while busy is ignored; there is no queueing.

## Timing
- Reset: state=IDLE, ready=1, done=0, found=0, recorded=0, overflow=0, count=0, full=0. Memory contents are not reset.
- Reset asserted mid-operation aborts the operation immediately. No done is produced, and no write occurs on that edge.
- Let E be the accept edge. RESP is entered at edge E+N, and done is high for the one cycle after that edge. N is:
  - hit at index h: h+1
  - query miss: count
  - record miss, not full: count+1
  - record miss, full: DEPTH (overflow)
  - count=0 query: 0
  - count=0 record: 1
- ready falls on the accept edge and rises on the edge that leaves RESP. The back-to-back request rate is therefore N+2 cycles.
- count and full update on the edge that leaves WRITE, together with the entry into RESP. The new values are visible while done=1.
- Wrap-around: none. count saturates at DEPTH, and the write index never exceeds DEPTH-1.

## Test plan
- After reset, issue record of ID 0 -> N=1, recorded=1, count=1. Then query ID 0 -> found=1, N=1. This checks that ID 0 is a legal ID.
- Record IDs 3, 7, 12, then record 7 again -> found=1, recorded=0, count stays 3, N=2.
- Fill all 16 entries with IDs 0..15 (WORD_SIZE=5), then record ID 20 -> overflow=1, count=16, full=1, N=16, and no write. Then query ID 15 -> found=1, N=16.
- With count=4, hold req while mode=0 -> no accept and no done. Then accept with mode=1 and drop control one cycle later -> the operation completes and done pulses once.
- At count=5, assert clear and req on the same edge -> count=0 and no done. Next, query ID 3 -> found=0, N=0.
- Assert reset during SCAN at count=8 -> the next cycle shows IDLE, count=0 and all flags 0, with no done pulse.

Source files
------------

// File: rtl/voter_id_registry.sv
// Registry of voter IDs that have already voted: sequential search per request,
// optional record of a new ID, duplicate/recorded/overflow status via req/ready/done.
module voter_id_registry #(
  parameter int unsigned WORD_SIZE    = 5,
  parameter int unsigned ADDRESS_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    control,
  input  logic                    req,
  input  logic                    op,
  input  logic [WORD_SIZE-1:0]    voter_id,
  input  logic                    clear,
  output logic                    ready,
  output logic                    done,
  output logic                    found,
  output logic                    recorded,
  output logic                    overflow,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    full
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_SIZE;
  localparam int unsigned CW    = ADDRESS_SIZE + 1;

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, RESP} state_t;

  state_t                  state, state_nxt;
  logic [WORD_SIZE-1:0]    mem [DEPTH];
  logic [WORD_SIZE-1:0]    id_q;
  logic                    op_q;
  logic [ADDRESS_SIZE-1:0] idx;

  logic accept_c, clear_c, hit_c, last_c, set_found_c, set_ovf_c;

  // clear has priority over a simultaneous request
  assign clear_c  = (state == IDLE) && clear;
  assign accept_c = (state == IDLE) && req && mode && control && !clear;
  assign hit_c    = (mem[idx] == id_q);
  assign last_c   = ({1'b0, idx} == (count - CW'(1)));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    set_found_c = 1'b0;
    set_ovf_c   = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (count != '0) state_nxt = SCAN;
          else if (op)     state_nxt = WRITE;
          else             state_nxt = RESP;
        end
      end
      SCAN: begin
        if (hit_c) begin
          set_found_c = 1'b1;
          state_nxt   = RESP;
        end else if (last_c) begin
          if (op_q && !full) begin
            state_nxt = WRITE;
          end else begin
            set_ovf_c = op_q;
            state_nxt = RESP;
          end
        end
      end
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control/status registers; ready and done are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      ready    <= 1'b1;
      done     <= 1'b0;
      found    <= 1'b0;
      recorded <= 1'b0;
      overflow <= 1'b0;
      count    <= '0;
      full     <= 1'b0;
      idx      <= '0;
      id_q     <= '0;
      op_q     <= 1'b0;
    end else begin
      ready <= (state_nxt == IDLE);
      done  <= (state_nxt == RESP);
      if (accept_c) begin
        id_q     <= voter_id;
        op_q     <= op;
        idx      <= '0;
        found    <= 1'b0;
        recorded <= 1'b0;
        overflow <= 1'b0;
      end else if (clear_c) begin
        count <= '0;
        full  <= 1'b0;
      end
      if (state == SCAN && !hit_c && !last_c) idx <= idx + ADDRESS_SIZE'(1);
      if (set_found_c) found <= 1'b1;
      if (set_ovf_c)   overflow <= 1'b1;
      if (state == WRITE) begin
        count    <= count + CW'(1);
        full     <= ((count + CW'(1)) == CW'(DEPTH));
        recorded <= 1'b1;
      end
    end
  end

  // WRITE is only reached when not full, so count indexes a free entry
  always_ff @(posedge clk) begin
    if (!reset && state == WRITE) mem[count[ADDRESS_SIZE-1:0]] <= id_q;
  end

endmodule

// File: tb/tb_voter_id_registry.sv
// Scoreboard bench for voter_id_registry: directed requests push expected results,
// a monitor pops and compares flags, count and latency on every done pulse.
module tb_voter_id_registry;

  localparam int unsigned WS = 5;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset, mode, control, req, op, clear;
  logic [WS-1:0] voter_id;
  logic          ready, done, found, recorded, overflow, full;
  logic [AW:0]   count;

  voter_id_registry #(.WORD_SIZE(WS), .ADDRESS_SIZE(AW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .control(control), .req(req), .op(op),
    .voter_id(voter_id), .clear(clear), .ready(ready), .done(done), .found(found),
    .recorded(recorded), .overflow(overflow), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic f, r, o, fl;
    int   cnt;
    int   lat;
    int   acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every done pulse against the oldest outstanding expectation
  always @(posedge clk) begin
    #1;
    if (done) begin
      done_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
      end else begin
        mon_e = q.pop_front();
        chk("found", int'(found), int'(mon_e.f));
        chk("recorded", int'(recorded), int'(mon_e.r));
        chk("overflow", int'(overflow), int'(mon_e.o));
        chk("count", int'(count), mon_e.cnt);
        chk("full", int'(full), int'(mon_e.fl));
        chk("latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || !ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout: got pending=%0d ready=%0d expected idle", q.size(), ready);
      q.delete();
    end
  endtask

  // Drive one accepted request; returns #1 after the accept edge
  task automatic issue(input logic o, input int id, input logic ef, input logic er,
                       input logic eo, input int ecnt, input logic efl, input int n);
    exp_t e;
    @(negedge clk);
    e.f = ef; e.r = er; e.o = eo; e.fl = efl; e.cnt = ecnt; e.lat = n; e.acc = cyc + 1;
    q.push_back(e);
    req = 1'b1; op = o; voter_id = WS'(id);
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic do_op(input logic o, input int id, input logic ef, input logic er,
                       input logic eo, input int ecnt, input logic efl, input int n);
    issue(o, id, ef, er, eo, ecnt, efl, n);
    wait_done();
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  int d0;

  initial begin
    reset = 1'b1; mode = 1'b1; control = 1'b1; req = 1'b0; op = 1'b0; clear = 1'b0;
    voter_id = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_flags", int'({found, recorded, overflow}), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_full", int'(full), 0);
    reset = 1'b0;

    // ID 0 is a legal voter ID
    do_op(1'b1, 0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1);
    do_op(1'b0, 0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1);

    // duplicate detection
    do_clear();
    chk("clear_count", int'(count), 0);
    do_op(1'b1, 3, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1);
    do_op(1'b1, 7, 1'b0, 1'b1, 1'b0, 2, 1'b0, 2);
    do_op(1'b1, 12, 1'b0, 1'b1, 1'b0, 3, 1'b0, 3);
    do_op(1'b1, 7, 1'b1, 1'b0, 1'b0, 3, 1'b0, 2);

    // fill, then overflow and last-entry hit
    do_clear();
    for (int i = 0; i < 16; i++)
      do_op(1'b1, i, 1'b0, 1'b1, 1'b0, i + 1, (i == 15), i + 1);
    do_op(1'b1, 20, 1'b0, 1'b0, 1'b1, 16, 1'b1, 16);
    do_op(1'b0, 20, 1'b0, 1'b0, 1'b0, 16, 1'b1, 16);
    do_op(1'b0, 15, 1'b1, 1'b0, 1'b0, 16, 1'b1, 16);

    // mode/control gating
    do_clear();
    for (int i = 1; i <= 4; i++)
      do_op(1'b1, i, 1'b0, 1'b1, 1'b0, i, 1'b0, i);
    d0 = done_cnt;
    @(negedge clk);
    mode = 1'b0; req = 1'b1; op = 1'b0; voter_id = WS'(3);
    repeat (5) @(negedge clk);
    chk("gated_ready", int'(ready), 1);
    chk("gated_no_done", done_cnt, d0);
    req = 1'b0; mode = 1'b1;
    issue(1'b0, 3, 1'b1, 1'b0, 1'b0, 4, 1'b0, 3);
    @(negedge clk);
    control = 1'b0;
    wait_done();
    control = 1'b1;
    repeat (3) @(negedge clk);
    chk("ctrl_drop_one_done", done_cnt, d0 + 1);

    // clear beats simultaneous req; flags untouched by clear
    do_op(1'b1, 5, 1'b0, 1'b1, 1'b0, 5, 1'b0, 5);
    d0 = done_cnt;
    @(negedge clk);
    clear = 1'b1; req = 1'b1; op = 1'b0; voter_id = WS'(3);
    @(negedge clk);
    clear = 1'b0; req = 1'b0;
    chk("clr_req_count", int'(count), 0);
    chk("clr_keeps_recorded", int'(recorded), 1);
    repeat (4) @(negedge clk);
    chk("clr_req_no_done", done_cnt, d0);
    do_op(1'b0, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);

    // reset during SCAN aborts with no done
    for (int i = 0; i < 8; i++)
      do_op(1'b1, 10 + i, 1'b0, 1'b1, 1'b0, i + 1, 1'b0, i + 1);
    d0 = done_cnt;
    issue(1'b1, 30, 1'b0, 1'b1, 1'b0, 9, 1'b0, 9);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    chk("abort_ready", int'(ready), 1);
    chk("abort_done", int'(done), 0);
    chk("abort_flags", int'({found, recorded, overflow}), 0);
    chk("abort_count", int'(count), 0);
    chk("abort_full", int'(full), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_idle_count", int'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
